// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the updown_counter family.
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of bits needed to represent the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/updown_counter_step.sv
// Combinational next-count for updown_counter: modulus wrap, or hold at the
// terminal value when UPDOWN_COUNTER_SAT_EN is defined.
module updown_counter_step
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             at_terminal
);

    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] next_ext;
    logic           unused_msb;

    always_comb begin
        q_ext       = {1'b0, q};
        next_ext    = q_ext;
        at_terminal = 1'b0;
        if (up == DIR_UP) begin
            at_terminal = (q_ext == LAST);
            next_ext    = at_terminal ? '0 : q_ext + 1'b1;
        end else begin
            at_terminal = (q_ext == '0);
            next_ext    = at_terminal ? LAST : q_ext - 1'b1;
        end
`ifdef UPDOWN_COUNTER_SAT_EN
        if (at_terminal) begin
            next_ext = q_ext;
        end
`endif
    end

    // Results always lie below MODULUS, so the extension bit is always clear.
    assign next_q     = next_ext[WIDTH-1:0];
    assign unused_msb = next_ext[WIDTH];

endmodule

// File: rtl/updown_counter.sv
// Synchronous up/down modulo-N counter with load, cascade carry, wrap pulse
// and sticky overflow. Define UPDOWN_COUNTER_SAT_EN for saturating mode.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic             carry_out,
    output logic             wrap,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH) || clog2(MODULUS) > WIDTH) begin : g_bad_params
            $error("updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST_Q  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_reg;
    logic             wrap_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] step_next;
    logic             at_terminal;
    logic [WIDTH-1:0] load_next;
    logic             wrap_next;

    updown_counter_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q           (q_reg),
        .up          (up),
        .next_q      (step_next),
        .at_terminal (at_terminal)
    );

    // Out-of-range load values clamp to the top of the count range.
    assign load_next = ({1'b0, load_val} < MOD_EXT) ? load_val : LAST_Q;
    assign wrap_next = ~load & en & at_terminal;

    always_ff @(posedge clock) begin
        if (clear) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            if (load) begin
                q_reg <= load_next;
            end else if (en) begin
                q_reg <= step_next;
            end
            wrap_reg <= wrap_next;
            // A wrap on the same edge beats an overflow clear.
            if (wrap_next) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign Q         = q_reg;
    assign wrap      = wrap_reg;
    assign ovf       = ovf_reg;
    assign carry_out = en & at_terminal;

endmodule
